// File: rtl/mesm6_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mesm6_mem_arbiter
// Purpose  : Merges the MESM-6 instruction-fetch bus and data bus onto one
//            shared word-wide memory port. A data access is served before a
//            fetch requested by the same microinstruction. All bus activity
//            of a microinstruction ends with a single aligned done cycle.
// Ports    : clk, reset (async, active-low)
//            ibus_fetch/ibus_addr -> ibus_input/ibus_done   (fetch side)
//            dbus_read/dbus_write/dbus_addr/dbus_output
//                                 -> dbus_input/dbus_done   (data side)
//            mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ack (memory)
// Revision : 1.0 - initial release
// ============================================================================
module mesm6_mem_arbiter #(
  parameter int AW = 15,
  parameter int DW = 48
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ibus_fetch,
  input  logic [AW-1:0] ibus_addr,
  output logic [DW-1:0] ibus_input,
  output logic          ibus_done,
  input  logic          dbus_read,
  input  logic          dbus_write,
  input  logic [AW-1:0] dbus_addr,
  input  logic [DW-1:0] dbus_output,
  output logic [DW-1:0] dbus_input,
  output logic          dbus_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_nx;
  logic          r_i_served, w_i_served_nx;
  logic          r_d_served, w_d_served_nx;
  logic          r_mem_req, w_mem_req_nx;
  logic          r_mem_we, w_mem_we_nx;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nx;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_nx;
  logic [DW-1:0] r_ibus_input, w_ibus_input_nx;
  logic [DW-1:0] r_dbus_input, w_dbus_input_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_i_served   <= 1'b0;
      r_d_served   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_ibus_input <= '0;
      r_dbus_input <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_i_served   <= w_i_served_nx;
      r_d_served   <= w_d_served_nx;
      r_mem_req    <= w_mem_req_nx;
      r_mem_we     <= w_mem_we_nx;
      r_mem_addr   <= w_mem_addr_nx;
      r_mem_wdata  <= w_mem_wdata_nx;
      r_ibus_input <= w_ibus_input_nx;
      r_dbus_input <= w_dbus_input_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_i_served_nx   = r_i_served;
    w_d_served_nx   = r_d_served;
    w_mem_req_nx    = r_mem_req;
    w_mem_we_nx     = r_mem_we;
    w_mem_addr_nx   = r_mem_addr;
    w_mem_wdata_nx  = r_mem_wdata;
    w_ibus_input_nx = r_ibus_input;
    w_dbus_input_nx = r_dbus_input;

    case (r_state)
      ST_IDLE: begin
        if (dbus_read || dbus_write) begin
          // Write wins when both read and write are asserted.
          w_state_nx     = ST_DATA;
          w_mem_addr_nx  = dbus_addr;
          w_mem_wdata_nx = dbus_output;
          w_mem_we_nx    = dbus_write;
          w_mem_req_nx   = 1'b1;
          w_d_served_nx  = 1'b1;
        end else if (ibus_fetch) begin
          w_state_nx    = ST_FETCH;
          w_mem_addr_nx = ibus_addr;
          w_mem_we_nx   = 1'b0;
          w_mem_req_nx  = 1'b1;
          w_i_served_nx = 1'b1;
        end
      end

      ST_DATA: begin
        if (mem_ack) begin
          if (!r_mem_we) begin
            w_dbus_input_nx = mem_rdata;
          end
          // A fetch pending in the same microinstruction follows directly,
          // keeping mem_req asserted across the address switch.
          if (ibus_fetch) begin
            w_state_nx    = ST_FETCH;
            w_mem_addr_nx = ibus_addr;
            w_mem_we_nx   = 1'b0;
            w_i_served_nx = 1'b1;
          end else begin
            w_state_nx   = ST_DONE;
            w_mem_req_nx = 1'b0;
          end
        end
      end

      ST_FETCH: begin
        if (mem_ack) begin
          w_ibus_input_nx = mem_rdata;
          w_mem_req_nx    = 1'b0;
          w_state_nx      = ST_DONE;
        end
      end

      ST_DONE: begin
        w_i_served_nx = 1'b0;
        w_d_served_nx = 1'b0;
        w_state_nx    = ST_IDLE;
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Both done strobes come from the same state decode, so they are always
  // coincident in the single DONE cycle.
  assign ibus_done  = (r_state == ST_DONE) && r_i_served;
  assign dbus_done  = (r_state == ST_DONE) && r_d_served;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign ibus_input = r_ibus_input;
  assign dbus_input = r_dbus_input;

endmodule
`default_nettype wire

// File: tb/tb_mesm6_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesm6_mem_arbiter
// Purpose  : Self-checking bench for mesm6_mem_arbiter. A driver issues
//            microinstructions and pushes expected memory transactions and
//            done results into queues; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesm6_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 48;
  localparam int MEM_WORDS = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ibus_fetch, dbus_read, dbus_write, mem_ack;
  logic [AW-1:0] ibus_addr, dbus_addr;
  logic [DW-1:0] dbus_output, mem_rdata;
  logic [DW-1:0] ibus_input, dbus_input, mem_wdata;
  logic          ibus_done, dbus_done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mesm6_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr),
    .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write),
    .dbus_addr(dbus_addr), .dbus_output(dbus_output),
    .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    logic          i;
    logic          d;
    logic [DW-1:0] iin;
    logic [DW-1:0] din;
    int            lat;
  } done_t;

  txn_t  txq[$];
  done_t dq[$];

  logic [DW-1:0] mem    [MEM_WORDS];   // memory behind the port
  logic [DW-1:0] refmem [MEM_WORDS];   // reference model's view of memory
  logic [DW-1:0] exp_i, exp_d;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  issue_cyc = 0;
  int  total_waits = 0;
  int  fixed_wait = 0;
  int  done_cnt = 0;
  bit  inject_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: each new transaction gets a wait count; ack never
  // arrives in the first cycle the transaction is visible.
  initial begin
    int wl;
    logic [63:0] junk;
    wl = -1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (inject_ack) begin
        mem_ack = 1'b1;
        mem_rdata = '1;
      end else if (mem_req) begin
        if (wl < 0) begin
          wl = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
          total_waits += wl;
        end else if (wl > 0) begin
          wl--;
        end else begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr[6:0]] = mem_wdata;
            junk = {$urandom(), $urandom()};
            mem_rdata = junk[DW-1:0];
          end else begin
            mem_rdata = mem[mem_addr[6:0]];
          end
          wl = -1;
        end
      end else begin
        wl = -1;
      end
    end
  end

  // Monitor: compares memory transactions at ack and results at done.
  logic          prev_req, prev_ack, prev_we;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    txn_t  t;
    done_t e;
    if (!reset) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (mem_req && prev_req && !prev_ack) begin
        chk("hold_we", mem_we, prev_we);
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_req && mem_ack) begin
        if (txq.size() == 0) begin
          chk("unexpected_txn", 1, 0);
        end else begin
          t = txq.pop_front();
          chk("txn_we", mem_we, t.we);
          chk("txn_addr", mem_addr, t.addr);
          if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
        end
      end
      if (ibus_done || dbus_done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = dq.pop_front();
          chk("ibus_done", ibus_done, e.i);
          chk("dbus_done", dbus_done, e.d);
          chk("ibus_input", ibus_input, e.iin);
          chk("dbus_input", dbus_input, e.din);
          chk("latency", cyc - issue_cyc, e.lat + total_waits);
          chk("req_low_in_done", mem_req, 0);
          chk("txns_all_done", txq.size(), 0);
        end
        done_cnt++;
      end
      prev_req   = mem_req;
      prev_ack   = mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  task automatic idle_inputs();
    ibus_fetch = 1'b0;
    dbus_read  = 1'b0;
    dbus_write = 1'b0;
  endtask

  // Issues one microinstruction (called just after a rising edge), records
  // what the memory and the core should see, and holds it until done.
  task automatic run_op(input bit rd, input bit wr, input bit f, input int da,
                        input int ia, input logic [DW-1:0] wd, input int gap);
    txn_t  t;
    done_t e;
    int    n;
    int    d0;
    if (rd || wr) begin
      t.we = wr; t.addr = AW'(da); t.wdata = wd;
      txq.push_back(t);
      if (wr) refmem[da] = wd;
      else    exp_d = refmem[da];
    end
    if (f) begin
      t.we = 1'b0; t.addr = AW'(ia); t.wdata = '0;
      txq.push_back(t);
      exp_i = refmem[ia];
    end
    e.i = f; e.d = rd || wr; e.iin = exp_i; e.din = exp_d;
    e.lat = ((rd || wr) && f) ? 5 : 3;
    dq.push_back(e);
    total_waits = 0;
    issue_cyc   = cyc;
    dbus_read   = rd;
    dbus_write  = wr;
    dbus_addr   = AW'(da);
    dbus_output = wd;
    ibus_fetch  = f;
    ibus_addr   = AW'(ia);
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) begin
      chk("timeout", 0, 1);
      txq.delete();
      dq.delete();
    end
    @(posedge clk);
    #1;
    if (gap > 0) begin
      idle_inputs();
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic [63:0] r64;
    bit rd, wr, f;
    reset = 1'b1;
    idle_inputs();
    ibus_addr = '0; dbus_addr = '0; dbus_output = '0;
    exp_i = '0; exp_d = '0;
    for (int i = 0; i < MEM_WORDS; i++) begin
      r64 = {$urandom(), $urandom()};
      mem[i] = r64[DW-1:0];
      refmem[i] = r64[DW-1:0];
    end

    #2 reset = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ibus_done", ibus_done, 0);
    chk("rst_dbus_done", dbus_done, 0);
    chk("rst_ibus_input", ibus_input, 0);
    chk("rst_dbus_input", dbus_input, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch, zero wait.
    fixed_wait = 0;
    mem[64] = 48'o1234; refmem[64] = 48'o1234;
    run_op(0, 0, 1, 64, 64, '0, 1);
    // Write with three wait states.
    fixed_wait = 3;
    run_op(0, 1, 0, 5, 0, 48'hA5A5_0000_FFFF, 1);
    // Read plus fetch in one microinstruction.
    fixed_wait = 0;
    run_op(1, 0, 1, 7, 8, '0, 1);
    // Back-to-back fetches with the request held across done.
    run_op(0, 0, 1, 0, 10, '0, 0);
    run_op(0, 0, 1, 0, 11, '0, 1);
    // Read and write both high.
    r64 = {$urandom(), $urandom()};
    run_op(1, 1, 0, 9, 0, r64[DW-1:0], 1);

    // Reset while a data access waits for its ack.
    fixed_wait = 50;
    dbus_write = 1'b1; dbus_addr = AW'(3); dbus_output = 48'h1111_2222_3333;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    chk("mid_rst_ibus_input", ibus_input, 0);
    chk("mid_rst_dbus_input", dbus_input, 0);
    idle_inputs();
    exp_i = '0; exp_d = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    // A stray ack while idle must change nothing.
    @(negedge clk);
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_dbus_input", dbus_input, 0);
    chk("late_ack_mem_req", mem_req, 0);
    @(posedge clk);
    #1;
    fixed_wait = 0;
    run_op(0, 0, 1, 0, 20, '0, 1);

    // Randomized microinstructions against the reference model.
    fixed_wait = -1;
    for (int k = 0; k < 60; k++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      f  = 1'($urandom_range(0, 1));
      if (!rd && !wr && !f) f = 1'b1;
      r64 = {$urandom(), $urandom()};
      run_op(rd, wr, f, int'($urandom_range(0, MEM_WORDS - 1)),
             int'($urandom_range(0, MEM_WORDS - 1)), r64[DW-1:0],
             int'($urandom_range(0, 2)));
    end
    idle_inputs();
    repeat (4) @(posedge clk);
    chk("queues_drained", txq.size() + dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
